// File: rtl/pe_stream_driver.sv
// ---------------------------------------------------------------------------
// pe_stream_driver
//
// Streams operand triples (ifmap, fltr, psum) from a valid/ready source into a
// processing element, one element per transfer, grouped into windows of K
// elements. Each completed window owes one PE result. Results are buffered
// in a small FIFO and drained through a valid/ready sink. A credit check at
// the first element of every window reserves FIFO space for all results
// still in flight, so the FIFO can never overflow.
//
// Optional feature macro: PE_DRV_WATCHDOG_EN
//   Defined   : an 8-bit watchdog runs while draining. If no PE result arrives
//               for 255 cycles it raises the sticky err flag, flushes the
//               FIFO and ends the job.
//   Undefined : no watchdog logic is built and err is tied low.
//
// Parameters
//   DATA_WIDTH      operand width; partial sums are 2*DATA_WIDTH wide
//   FIFO_DEPTH      result FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start                     job start pulse (honoured in IDLE only)
//   cfg_kernel_size [2:0]     K, elements per window
//   cfg_num_win     [7:0]     N, windows per job
//   busy, done, err           status: not idle, job-complete pulse, watchdog
//   src_valid/src_ready       operand source handshake
//   src_ifmap/fltr/psum       operand triple
//   pe_en                     one pulse per delivered element
//   pe_ifmap/fltr/psum        registered operands to the PE
//   pe_kernel_size  [2:0]     latched K
//   pe_valid, pe_psum_res     PE result strobe and data
//   dst_valid/dst_ready       result sink handshake
//   dst_data, dst_last        result word, marks the Nth result of the job
// ---------------------------------------------------------------------------
module pe_stream_driver #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              cfg_kernel_size,
  input  logic [7:0]              cfg_num_win,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [DATA_WIDTH-1:0]   src_ifmap,
  input  logic [DATA_WIDTH-1:0]   src_fltr,
  input  logic [2*DATA_WIDTH-1:0] src_psum,
  output logic                    pe_en,
  output logic [DATA_WIDTH-1:0]   pe_ifmap,
  output logic [DATA_WIDTH-1:0]   pe_fltr,
  output logic [2*DATA_WIDTH-1:0] pe_psum,
  output logic [2:0]              pe_kernel_size,
  input  logic                    pe_valid,
  input  logic [2*DATA_WIDTH-1:0] pe_psum_res,
  output logic                    dst_valid,
  input  logic                    dst_ready,
  output logic [2*DATA_WIDTH-1:0] dst_data,
  output logic                    dst_last
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  // Job configuration and progress counters
  logic [2:0]    k_q;
  logic [7:0]    n_q;
  logic [2:0]    elem_cnt_q;
  logic [7:0]    win_cnt_q;
  logic [7:0]    ret_cnt_q;
  logic [7:0]    pop_cnt_q;
  logic [CW-1:0] outst_q;

  // Result FIFO
  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Datapath control
  logic          start_ok;
  logic          cfg_zero;
  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          xfer;
  logic          elem_last;
  logic          win_issue;
  logic          win_last;
  logic          res_acc;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;
  logic [7:0]    ret_next;
  logic          wd_trip;

  assign start_ok  = (state_q == IDLE) && start;
  assign cfg_zero  = (cfg_kernel_size == 3'd0) || (cfg_num_win == 8'd0);

  // Results already buffered plus results still owed by the PE must leave
  // room for one more window before a new window may begin.
  assign credit_sum = {1'b0, count_q} + {1'b0, outst_q};
  assign credit_ok  = credit_sum < (CW + 1)'(FIFO_DEPTH);

  assign src_ready = (state_q == STREAM) && ((elem_cnt_q != 3'd0) || credit_ok);
  assign xfer      = src_valid && src_ready;
  assign elem_last = (elem_cnt_q == (k_q - 3'd1));
  assign win_issue = xfer && elem_last;
  assign win_last  = win_issue && (win_cnt_q == (n_q - 8'd1));

  // A result strobe is only meaningful while a window is owed.
  assign res_acc    = pe_valid && (outst_q != '0);
  assign push       = res_acc;
  assign pop        = dst_valid && dst_ready;
  assign count_next = count_q + CW'(push) - CW'(pop);
  assign ret_next   = ret_cnt_q + 8'(res_acc);

  // -------------------------------------------------------------------------
  // Optional drain watchdog
  // -------------------------------------------------------------------------
`ifdef PE_DRV_WATCHDOG_EN
  logic [7:0] wd_q;
  logic       err_q;

  // The counter holds at zero outside DRAIN, so DRAIN always starts fresh;
  // the trip fires on the cycle the count would reach 255.
  assign wd_trip = (state_q == DRAIN) && !res_acc && (wd_q == 8'd254);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q != DRAIN) || res_acc) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + 8'd1;
      end
      if (wd_trip) begin
        err_q <= 1'b1;
      end else if (start_ok) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  assign wd_trip = 1'b0;
  assign err     = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = cfg_zero ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (win_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish once every result has arrived and the last word leaves the
        // FIFO this cycle (or it already has).
        if (wd_trip) begin
          state_d = DONE;
        end else if ((ret_next == n_q) && (count_next == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Counters, operand registers and FIFO pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      n_q        <= '0;
      elem_cnt_q <= '0;
      win_cnt_q  <= '0;
      ret_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      outst_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pe_en      <= 1'b0;
      pe_ifmap   <= '0;
      pe_fltr    <= '0;
      pe_psum    <= '0;
    end else begin
      pe_en <= xfer;
      if (xfer) begin
        pe_ifmap   <= src_ifmap;
        pe_fltr    <= src_fltr;
        pe_psum    <= src_psum;
        elem_cnt_q <= elem_last ? '0 : elem_cnt_q + 3'd1;
      end

      if (win_issue) begin
        win_cnt_q <= win_cnt_q + 8'd1;
      end

      if (win_issue && !res_acc) begin
        outst_q <= outst_q + CW'(1);
      end else if (!win_issue && res_acc) begin
        outst_q <= outst_q - CW'(1);
      end

      ret_cnt_q <= ret_next;
      if (pop) begin
        pop_cnt_q <= pop_cnt_q + 8'd1;
      end

      if (wd_trip) begin
        // Abandon the job: drop buffered words and forget owed results.
        outst_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        count_q <= count_next;
      end

      if (start_ok) begin
        k_q        <= cfg_kernel_size;
        n_q        <= cfg_num_win;
        elem_cnt_q <= '0;
        win_cnt_q  <= '0;
        ret_cnt_q  <= '0;
        pop_cnt_q  <= '0;
        outst_q    <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !wd_trip) begin
      mem[wr_ptr_q] <= pe_psum_res;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign pe_kernel_size = k_q;
  assign dst_valid      = (count_q != '0);
  // Head data is masked when empty so the port reads zero after reset.
  assign dst_data       = dst_valid ? mem[rd_ptr_q] : '0;
  // The head is result number pop_cnt_q+1 because order is preserved.
  assign dst_last       = dst_valid && (pop_cnt_q == (n_q - 8'd1));

endmodule

// File: tb/tb_pe_stream_driver.sv
module tb_pe_stream_driver;

  localparam int DW    = 16;
  localparam int PW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    cfg_kernel_size;
  logic [7:0]    cfg_num_win;
  logic          busy, done, err;
  logic          src_valid, src_ready;
  logic [DW-1:0] src_ifmap, src_fltr;
  logic [PW-1:0] src_psum;
  logic          pe_en;
  logic [DW-1:0] pe_ifmap, pe_fltr;
  logic [PW-1:0] pe_psum;
  logic [2:0]    pe_kernel_size;
  logic          pe_valid;
  logic [PW-1:0] pe_psum_res;
  logic          dst_valid, dst_ready;
  logic [PW-1:0] dst_data;
  logic          dst_last;

  always #5 clk = ~clk;

  pe_stream_driver #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_kernel_size(cfg_kernel_size), .cfg_num_win(cfg_num_win),
    .busy(busy), .done(done), .err(err),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_ifmap(src_ifmap), .src_fltr(src_fltr), .src_psum(src_psum),
    .pe_en(pe_en), .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr), .pe_psum(pe_psum),
    .pe_kernel_size(pe_kernel_size),
    .pe_valid(pe_valid), .pe_psum_res(pe_psum_res),
    .dst_valid(dst_valid), .dst_ready(dst_ready),
    .dst_data(dst_data), .dst_last(dst_last)
  );

  // ---------------- PE model: window sum returned 4 cycles after last pe_en
  typedef struct {
    int unsigned   due;
    logic [PW-1:0] data;
  } pe_ret_t;

  pe_ret_t       pm_q[$];
  int unsigned   pm_cyc = 0;
  int unsigned   pm_n   = 0;
  logic [PW-1:0] pm_acc = '0;
  bit            pe_ret_en = 1'b1;
  bit            spur      = 1'b0;

  always @(negedge clk) begin
    pm_cyc++;
    if (rst) begin
      pm_q.delete();
      pm_n        = 0;
      pm_acc      = '0;
      pe_valid    = 1'b0;
      pe_psum_res = '0;
    end else begin
      if (pe_en) begin
        if (pm_n == 0) pm_acc = pe_psum;
        pm_acc = pm_acc + PW'(pe_ifmap) * PW'(pe_fltr);
        pm_n++;
        if (pm_n == int'(pe_kernel_size)) begin
          if (pe_ret_en) pm_q.push_back('{due: pm_cyc + 4, data: pm_acc});
          pm_n = 0;
        end
      end
      pe_valid    = 1'b0;
      pe_psum_res = '0;
      if (pm_q.size() != 0 && pm_q[0].due == pm_cyc) begin
        pe_valid    = 1'b1;
        pe_psum_res = pm_q[0].data;
        void'(pm_q.pop_front());
      end else if (spur) begin
        pe_valid    = 1'b1;
        pe_psum_res = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- scoreboard, source queue, bookkeeping
  typedef struct {
    logic [PW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] q_if[$];
  logic [DW-1:0] q_fl[$];
  logic [PW-1:0] q_ps[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc = 0, pe_en_cnt = 0, done_cnt = 0, busy_cnt = 0, dv_cnt = 0;
  int pop_cnt = 0, xfer_cnt = 0, done_cyc = 0, last_pop_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    src_valid = (q_if.size() != 0);
    src_ifmap = src_valid ? q_if[0] : '0;
    src_fltr  = src_valid ? q_fl[0] : '0;
    src_psum  = src_valid ? q_ps[0] : '0;
  endtask

  task automatic push_elem(input logic [DW-1:0] i, input logic [DW-1:0] f, input logic [PW-1:0] p);
    q_if.push_back(i);
    q_fl.push_back(f);
    q_ps.push_back(p);
  endtask

  // Queue k*n operands and the window results they should produce:
  // result = psum of first element + sum of ifmap*fltr over the window.
  task automatic add_job(input int k, input int n, input int ifb, input int fl, input int psb);
    logic [PW-1:0] acc;
    logic [DW-1:0] ifm, flt;
    logic [PW-1:0] ps;
    for (int w = 0; w < n; w++) begin
      acc = '0;
      for (int e = 0; e < k; e++) begin
        ifm = DW'(ifb + w * k + e);
        flt = DW'(fl);
        ps  = PW'(psb * (w * k + e));
        if (e == 0) acc = ps;
        acc = acc + PW'(ifm) * PW'(flt);
        push_elem(ifm, flt, ps);
      end
      sb.push_back('{d: acc, l: (w == n - 1)});
    end
    drive_src();
  endtask

  // Sample at negedge (handshakes resolve at the next posedge), then step
  // past the edge and advance the source queue if a transfer happened.
  task automatic tick();
    bit   hs_src, hs_dst;
    exp_t e;
    @(negedge clk);
    cyc++;
    hs_src = src_valid && src_ready;
    hs_dst = dst_valid && dst_ready;
    if (pe_en) pe_en_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (dst_valid) dv_cnt++;
    if (hs_dst) begin
      pop_cnt++;
      last_pop_cyc = cyc;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("dst_data", dst_data, e.d);
        chk("dst_last", dst_last, e.l);
      end
    end
    if (hs_src) xfer_cnt++;
    @(posedge clk);
    #1;
    if (hs_src) begin
      void'(q_if.pop_front());
      void'(q_fl.pop_front());
      void'(q_ps.pop_front());
    end
    drive_src();
  endtask

  task automatic run_until_done(input int limit, output bit ok);
    int base;
    base = done_cnt;
    ok   = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_job(input logic [2:0] k, input logic [7:0] n);
    cfg_kernel_size = k;
    cfg_num_win     = n;
    start           = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int b_pe, b_pop, b_done, b_busy, b_x, b_dv, n_t;

    rst = 1'b1; start = 1'b0; cfg_kernel_size = '0; cfg_num_win = '0;
    dst_ready = 1'b0;
    drive_src();
    repeat (2) tick();

    // ---- reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_pe_en", pe_en, 0);
    chk("rst_dst_valid", dst_valid, 0);
    chk("rst_dst_last", dst_last, 0);
    chk("rst_dst_data", dst_data, 0);
    chk("rst_pe_ksize", pe_kernel_size, 0);
    chk("rst_pe_ifmap", pe_ifmap, 0);
    rst = 1'b0;
    tick();

    // ---- K=3 N=2: ifmap 1..6, fltr 2, psum 0 -> 12 then 30
    dst_ready = 1'b1;
    add_job(3, 2, 1, 2, 0);
    b_pe = pe_en_cnt; b_pop = pop_cnt; b_done = done_cnt;
    start_job(3'd3, 8'd2);
    chk("A_busy", busy, 1);
    chk("A_ksize", pe_kernel_size, 3);
    run_until_done(200, ok);
    chk("A_done_seen", ok, 1);
    chk("A_pe_en", pe_en_cnt - b_pe, 6);
    chk("A_pops", pop_cnt - b_pop, 2);
    chk("A_done_after_pop", done_cyc - last_pop_cyc, 1);
    chk("A_sb_empty", sb.size(), 0);
    tick();
    chk("A_idle", busy, 0);
    chk("A_done_once", done_cnt - b_done, 1);

    // ---- K=0: immediate DONE, no transfers, busy for one cycle
    b_pe = pe_en_cnt; b_busy = busy_cnt; b_done = done_cnt;
    start_job(3'd0, 8'd5);
    chk("B_done", done, 1);
    repeat (3) tick();
    chk("B_busy_cycles", busy_cnt - b_busy, 1);
    chk("B_done_cnt", done_cnt - b_done, 1);
    chk("B_pe_en", pe_en_cnt - b_pe, 0);
    // N=0 also skips streaming
    start_job(3'd3, 8'd0);
    chk("B2_done", done, 1);
    tick();

    // ---- K=1 N=8 with sink stalled: credits stop after FIFO_DEPTH windows
    dst_ready = 1'b0;
    add_job(1, 8, 10, 3, 100);
    b_pe = pe_en_cnt; b_pop = pop_cnt;
    start_job(3'd1, 8'd8);
    repeat (40) tick();
    chk("C_pe_en_stalled", pe_en_cnt - b_pe, DEPTH);
    chk("C_src_ready", src_ready, 0);
    chk("C_dst_valid", dst_valid, 1);
    // Full FIFO: pop and a PE strobe in the same cycle. Nothing is owed, so
    // the strobe must not add a word; the scoreboard sees any stray data.
    dst_ready = 1'b1;
    spur      = 1'b1;
    tick();
    spur = 1'b0;
    run_until_done(300, ok);
    chk("C_done_seen", ok, 1);
    chk("C_pops", pop_cnt - b_pop, 8);
    chk("C_pe_en", pe_en_cnt - b_pe, 8);
    chk("C_sb_empty", sb.size(), 0);
    tick();

    // ---- reset mid-stream after 3 transfers, then a normal job
    push_elem(16'd7, 16'd1, 32'd0);
    push_elem(16'd8, 16'd1, 32'd0);
    push_elem(16'd9, 16'd1, 32'd0);
    drive_src();
    b_x = xfer_cnt; b_done = done_cnt;
    start_job(3'd4, 8'd2);
    n_t = 0;
    while ((xfer_cnt - b_x) < 3 && n_t < 20) begin
      tick();
      n_t++;
    end
    chk("D_three_xfers", xfer_cnt - b_x, 3);
    tick();
    rst = 1'b1;
    tick();
    chk("D_busy", busy, 0);
    chk("D_done", done, 0);
    chk("D_err", err, 0);
    chk("D_src_ready", src_ready, 0);
    chk("D_pe_en", pe_en, 0);
    chk("D_pe_ifmap", pe_ifmap, 0);
    chk("D_pe_ksize", pe_kernel_size, 0);
    chk("D_dst_valid", dst_valid, 0);
    rst = 1'b0;
    tick();
    chk("D_no_done", done_cnt - b_done, 0);
    add_job(2, 1, 20, 5, 7);
    b_pop = pop_cnt;
    start_job(3'd2, 8'd1);
    run_until_done(100, ok);
    chk("D2_done_seen", ok, 1);
    chk("D2_pops", pop_cnt - b_pop, 1);
    chk("D2_sb_empty", sb.size(), 0);
    tick();

`ifdef PE_DRV_WATCHDOG_EN
    // ---- watchdog: PE never answers
    pe_ret_en = 1'b0;
    push_elem(16'd1, 16'd1, 32'd0);
    push_elem(16'd2, 16'd1, 32'd0);
    drive_src();
    b_x = xfer_cnt; b_dv = dv_cnt; b_done = done_cnt;
    start_job(3'd2, 8'd1);
    n_t = 0;
    while ((xfer_cnt - b_x) < 2 && n_t < 20) begin
      tick();
      n_t++;
    end
    chk("E_xfers", xfer_cnt - b_x, 2);
    // Now just past the edge that entered DRAIN. DONE starts 255 cycles
    // later, which is first sampled on the 256th tick from here.
    n_t = 0;
    while (done_cnt == b_done && n_t < 400) begin
      tick();
      n_t++;
    end
    chk("E_wd_ticks", n_t, 256);
    chk("E_err", err, 1);
    chk("E_dst_valid_never", dv_cnt - b_dv, 0);
    start_job(3'd0, 8'd1);
    chk("E_err_cleared", err, 0);
    tick();
    pe_ret_en = 1'b1;
`else
    chk("E_err_tied", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
